// File: rtl/if_pkg.sv
// Shared definitions for the instruction fetch stage: reset PC, PC step and
// fetch FSM states.
package if_pkg;

    localparam int unsigned RESET_PC = 0;
    localparam int unsigned PC_INC   = 4;

    typedef enum logic [1:0] {
        StReset = 2'd0,
        StFetch = 2'd1,
        StStall = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage (master)
// and instruction memory (slave).
interface instruction_fetch_if #(
    parameter int unsigned IWIDTH = 32,
    parameter int unsigned AWIDTH = 32
);
    logic              f_o_syn;
    logic [AWIDTH-1:0] f_o_addr_instr;
    logic [IWIDTH-1:0] f_i_instr;
    logic              f_i_ack;

    modport master (
        output f_o_syn,
        output f_o_addr_instr,
        input  f_i_instr,
        input  f_i_ack
    );

    modport slave (
        input  f_o_syn,
        input  f_o_addr_instr,
        output f_i_instr,
        output f_i_ack
    );
endinterface

// File: rtl/if_pc_gen.sv
// Fetch-PC register: redirect load, hold, or advance by one instruction word.
// With FETCH_ALIGN_EN defined, redirect targets are forced word-aligned.
module if_pc_gen
    import if_pkg::*;
#(
    parameter int unsigned PC_WIDTH = 32
) (
    input  logic                f_clk,
    input  logic                f_rst,
    input  logic                change_pc,
    input  logic [PC_WIDTH-1:0] target,
    input  logic                advance,
    output logic [PC_WIDTH-1:0] pc
);

    logic [PC_WIDTH-1:0] pc_q, pc_d, target_eff;

    // Redirect target, optionally word-aligned.
    always_comb begin
        target_eff = target;
`ifdef FETCH_ALIGN_EN
        target_eff[1:0] = 2'b00;
`endif
    end

    // Next PC: redirect wins over advance; otherwise hold. Addition wraps.
    always_comb begin
        pc_d = pc_q;
        if (change_pc) begin
            pc_d = target_eff;
        end else if (advance) begin
            pc_d = pc_q + PC_WIDTH'(PC_INC);
        end
    end

    // PC register with asynchronous reset.
    always_ff @(posedge f_clk or negedge f_rst) begin
        if (!f_rst) begin
            pc_q <= PC_WIDTH'(RESET_PC);
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: holds the PC, issues instruction-memory requests and presents
// each acknowledged instruction with its PC and a one-cycle f_o_ce strobe.
// Optional macro FETCH_ALIGN_EN word-aligns redirect targets (see if_pc_gen).
module instruction_fetch
    import if_pkg::*;
#(
    parameter int unsigned IWIDTH   = 32,
    parameter int unsigned AWIDTH   = 32,
    parameter int unsigned PC_WIDTH = 32
) (
    input  logic                f_clk,
    input  logic                f_rst,
    instruction_fetch_if.master mem,
    output logic [IWIDTH-1:0]   f_o_instr,
    output logic [PC_WIDTH-1:0] f_pc,
    output logic                f_o_ce,
    input  logic                f_change_pc,
    input  logic [PC_WIDTH-1:0] f_alu_pc_value,
    input  logic                f_i_stall
);

    fetch_state_e        state_q, state_d;
    logic [IWIDTH-1:0]   instr_q, instr_d;
    logic [PC_WIDTH-1:0] pc_out_q, pc_out_d;
    logic                ce_q, ce_d;
    logic [PC_WIDTH-1:0] fetch_pc;
    logic                syn;
    logic                accept;

    // Request is valid only in FETCH; it is a decode of a registered state.
    assign syn    = (state_q == StFetch);
    // Ack counts only for an outstanding request with no stall or redirect.
    assign accept = syn && mem.f_i_ack && !f_i_stall && !f_change_pc;

    if_pc_gen #(
        .PC_WIDTH (PC_WIDTH)
    ) u_pc_gen (
        .f_clk     (f_clk),
        .f_rst     (f_rst),
        .change_pc (f_change_pc),
        .target    (f_alu_pc_value),
        .advance   (accept),
        .pc        (fetch_pc)
    );

    // Next-state and output-register update; priority redirect > stall > ack.
    always_comb begin
        state_d  = StFetch;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        ce_d     = 1'b0;
        if (f_change_pc) begin
            state_d = StFetch;
        end else if (f_i_stall) begin
            state_d = StStall;
            ce_d    = ce_q;
        end else if (accept) begin
            instr_d  = mem.f_i_instr;
            pc_out_d = fetch_pc;
            ce_d     = 1'b1;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge f_clk or negedge f_rst) begin
        if (!f_rst) begin
            state_q  <= StReset;
            instr_q  <= '0;
            pc_out_q <= '0;
            ce_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            ce_q     <= ce_d;
        end
    end

    assign mem.f_o_syn        = syn;
    assign mem.f_o_addr_instr = AWIDTH'(fetch_pc);
    assign f_o_instr          = instr_q;
    assign f_pc               = pc_out_q;
    assign f_o_ce             = ce_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: stimulus pushes expected captures,
// a monitor pops and compares on every f_o_ce strobe.
module tb_instruction_fetch;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    logic        f_clk = 1'b0;
    logic        f_rst;
    logic [31:0] f_o_instr;
    logic [31:0] f_pc;
    logic        f_o_ce;
    logic        f_change_pc;
    logic [31:0] f_alu_pc_value;
    logic        f_i_stall;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    instruction_fetch_if #(.IWIDTH(32), .AWIDTH(32)) bus ();

    instruction_fetch #(
        .IWIDTH   (32),
        .AWIDTH   (32),
        .PC_WIDTH (32)
    ) dut (
        .f_clk          (f_clk),
        .f_rst          (f_rst),
        .mem            (bus),
        .f_o_instr      (f_o_instr),
        .f_pc           (f_pc),
        .f_o_ce         (f_o_ce),
        .f_change_pc    (f_change_pc),
        .f_alu_pc_value (f_alu_pc_value),
        .f_i_stall      (f_i_stall)
    );

    always #5 f_clk = ~f_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge f_clk);
        #1;
    endtask

    task automatic ack_word(input logic [31:0] word, input logic [31:0] pc);
        exp_t e;
        e.instr = word;
        e.pc    = pc;
        exp_q.push_back(e);
        bus.f_i_ack   = 1'b1;
        bus.f_i_instr = word;
        step();
        bus.f_i_ack   = 1'b0;
        bus.f_i_instr = 32'h0;
    endtask

    // Monitor: every strobe must match the oldest expected capture.
    always @(negedge f_clk) begin
        if (f_o_ce === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ce", {31'h0, f_o_ce}, 32'h0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_instr", f_o_instr, e.instr);
                check("sb_pc", f_pc, e.pc);
            end
        end
    end

    initial begin
        f_rst          = 1'b0;
        f_change_pc    = 1'b0;
        f_alu_pc_value = 32'h0;
        f_i_stall      = 1'b0;
        bus.f_i_ack    = 1'b0;
        bus.f_i_instr  = 32'h0;

        // Reset for two cycles.
        step();
        step();
        check("rst_syn", {31'h0, bus.f_o_syn}, 32'h0);
        check("rst_addr", bus.f_o_addr_instr, 32'h0);
        check("rst_ce", {31'h0, f_o_ce}, 32'h0);
        check("rst_instr", f_o_instr, 32'h0);
        check("rst_pc", f_pc, 32'h0);
        f_rst = 1'b1;
        step();
        check("first_syn", {31'h0, bus.f_o_syn}, 32'h1);
        check("first_addr", bus.f_o_addr_instr, 32'h0);

        // Three captures, each followed by an idle cycle.
        ack_word(32'hA0A0A0A0, 32'h0);
        check("addr_after_a", bus.f_o_addr_instr, 32'h4);
        step();
        check("idle_ce", {31'h0, f_o_ce}, 32'h0);
        ack_word(32'hB1B1B1B1, 32'h4);
        step();
        ack_word(32'hC2C2C2C2, 32'h8);
        step();
        check("addr_c", bus.f_o_addr_instr, 32'hC);

        // Three-cycle stall with a spurious ack that must be ignored.
        f_i_stall     = 1'b1;
        bus.f_i_ack   = 1'b1;
        bus.f_i_instr = 32'h99999999;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_syn", {31'h0, bus.f_o_syn}, 32'h0);
            check("stall_instr", f_o_instr, 32'hC2C2C2C2);
            check("stall_addr", bus.f_o_addr_instr, 32'hC);
        end
        f_i_stall   = 1'b0;
        bus.f_i_ack = 1'b0;
        step();
        check("unstall_syn", {31'h0, bus.f_o_syn}, 32'h1);
        ack_word(32'hD3D3D3D3, 32'hC);
        check("addr_d", bus.f_o_addr_instr, 32'h10);
        step();

        // Redirect with a simultaneous ack: ack discarded, bubble.
        f_change_pc    = 1'b1;
        f_alu_pc_value = 32'h100;
        bus.f_i_ack    = 1'b1;
        bus.f_i_instr  = 32'hDEADBEEF;
        step();
        f_change_pc   = 1'b0;
        bus.f_i_ack   = 1'b0;
        check("redir_addr", bus.f_o_addr_instr, 32'h100);
        check("redir_ce", {31'h0, f_o_ce}, 32'h0);
        check("redir_instr", f_o_instr, 32'hD3D3D3D3);
        ack_word(32'hE4E4E4E4, 32'h100);
        step();
        ack_word(32'hF5F5F5F5, 32'h104);
        check("addr_f", bus.f_o_addr_instr, 32'h108);
        step();

        // Unaligned redirect together with stall: redirect wins.
        f_change_pc    = 1'b1;
        f_i_stall      = 1'b1;
        f_alu_pc_value = 32'h102;
        step();
        f_change_pc = 1'b0;
        f_i_stall   = 1'b0;
`ifdef FETCH_ALIGN_EN
        check("align_addr", bus.f_o_addr_instr, 32'h100);
`else
        check("align_addr", bus.f_o_addr_instr, 32'h102);
`endif
        check("redir_stall_syn", {31'h0, bus.f_o_syn}, 32'h1);
        check("redir_stall_pc", f_pc, 32'h104);

        // Asynchronous reset between edges.
        #2;
        f_rst = 1'b0;
        #1;
        check("arst_syn", {31'h0, bus.f_o_syn}, 32'h0);
        check("arst_addr", bus.f_o_addr_instr, 32'h0);
        check("arst_instr", f_o_instr, 32'h0);
        check("arst_pc", f_pc, 32'h0);
        step();
        f_rst = 1'b1;
        step();
        check("rerelease_syn", {31'h0, bus.f_o_syn}, 32'h1);

        // PC wrap at the top of the address space.
        f_change_pc    = 1'b1;
        f_alu_pc_value = 32'hFFFFFFFC;
        step();
        f_change_pc = 1'b0;
        check("wrap_target", bus.f_o_addr_instr, 32'hFFFFFFFC);
        ack_word(32'h11223344, 32'hFFFFFFFC);
        check("wrap_addr", bus.f_o_addr_instr, 32'h0);
        step();
        step();

        check("sb_drained", exp_q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
